// File: rtl/ptw_mem_adapter.sv
// Memory-port adapter: arbitrates MMU page-table-walk reads against core load/store
// traffic onto a single data-memory bus, one transaction in flight at a time.
// A bus that never answers is turned into an all-zero response after TIMEOUT cycles
// so the MMU sees an invalid PTE and faults instead of hanging.
module ptw_mem_adapter #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  // MMU page-table-walk port
  input  logic            ptw_req_valid,
  input  logic [XLEN-1:0] ptw_req_addr,
  output logic            ptw_req_ready,
  output logic            ptw_resp_valid,
  output logic [XLEN-1:0] ptw_resp_data,
  // Core data port
  input  logic            dmem_req_valid,
  input  logic [XLEN-1:0] dmem_req_addr,
  input  logic            dmem_req_we,
  input  logic [XLEN-1:0] dmem_req_wdata,
  output logic            dmem_req_ready,
  output logic            dmem_resp_valid,
  output logic [XLEN-1:0] dmem_resp_data,
  output logic            dmem_resp_err,
  // Memory bus
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data
);

  // PTEs are XLEN/8 bytes wide; PTW addresses are rounded down to that size.
  localparam int unsigned    OffW      = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] AlignMask = {XLEN{1'b1}} << OffW;
  localparam logic [7:0]      CntLast   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e          state_q;
  logic            owner_ptw_q;  // 1: transaction belongs to the PTW, 0: to the core
  logic            err_q;        // last completion was a timeout
  logic [7:0]      cnt_q;
  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;
  logic            mem_req_valid_q;
  logic            ptw_resp_valid_q;
  logic            dmem_resp_valid_q;
  logic [XLEN-1:0] ptw_resp_data_q;
  logic [XLEN-1:0] dmem_resp_data_q;

  logic            wait_done;
  logic [XLEN-1:0] resp_data;

  // Request acceptance: only in IDLE, PTW has fixed priority over the core.
  always_comb begin
    ptw_req_ready  = (state_q == StIdle) & ptw_req_valid;
    dmem_req_ready = (state_q == StIdle) & dmem_req_valid & ~ptw_req_valid;
  end

  // WAIT exit: a real response always wins over a timeout landing in the same cycle.
  always_comb begin
    wait_done = mem_resp_valid | (cnt_q == CntLast);
    resp_data = mem_resp_valid ? mem_resp_data : '0;
  end

  // Transaction FSM with registered bus request and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      owner_ptw_q       <= 1'b0;
      err_q             <= 1'b0;
      cnt_q             <= '0;
      addr_q            <= '0;
      we_q              <= 1'b0;
      wdata_q           <= '0;
      mem_req_valid_q   <= 1'b0;
      ptw_resp_valid_q  <= 1'b0;
      dmem_resp_valid_q <= 1'b0;
      ptw_resp_data_q   <= '0;
      dmem_resp_data_q  <= '0;
    end else begin
      ptw_resp_valid_q  <= 1'b0;
      dmem_resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ptw_req_valid) begin
            owner_ptw_q     <= 1'b1;
            addr_q          <= ptw_req_addr & AlignMask;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b1;
            state_q         <= StReq;
          end else if (dmem_req_valid) begin
            owner_ptw_q     <= 1'b0;
            addr_q          <= dmem_req_addr;
            we_q            <= dmem_req_we;
            wdata_q         <= dmem_req_wdata;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b1;
            state_q         <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (wait_done) begin
            err_q   <= ~mem_resp_valid;
            state_q <= StResp;
            if (owner_ptw_q) begin
              ptw_resp_valid_q <= 1'b1;
              ptw_resp_data_q  <= resp_data;
            end else begin
              dmem_resp_valid_q <= 1'b1;
              dmem_resp_data_q  <= resp_data;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_addr    = addr_q;
  assign mem_req_we      = we_q;
  assign mem_req_wdata   = wdata_q;
  assign ptw_resp_valid  = ptw_resp_valid_q;
  assign ptw_resp_data   = ptw_resp_data_q;
  assign dmem_resp_valid = dmem_resp_valid_q;
  assign dmem_resp_data  = dmem_resp_data_q;
  // The error flag is only visible alongside a core completion.
  assign dmem_resp_err   = dmem_resp_valid_q & err_q;

endmodule

// File: tb/tb_ptw_mem_adapter.sv
// Self-checking bench for ptw_mem_adapter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_ptw_mem_adapter;

  localparam int unsigned XLEN = 64;
  localparam int          TO   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            ptw_req_valid;
  logic [XLEN-1:0] ptw_req_addr;
  logic            ptw_req_ready;
  logic            ptw_resp_valid;
  logic [XLEN-1:0] ptw_resp_data;
  logic            dmem_req_valid;
  logic [XLEN-1:0] dmem_req_addr;
  logic            dmem_req_we;
  logic [XLEN-1:0] dmem_req_wdata;
  logic            dmem_req_ready;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_data;
  logic            dmem_resp_err;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  ptw_mem_adapter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_addr   (ptw_req_addr),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_data  (ptw_resp_data),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_ready (dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data (dmem_resp_data),
    .dmem_resp_err  (dmem_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from IDLE back to IDLE and reports what was observed.
  // stray counts pulses on the wrong port, pulses longer than a cycle and ready while busy.
  task automatic do_txn(input bit is_ptw, input logic [63:0] addr, input bit we,
                        input logic [63:0] wdata, input int stall, input int resp_delay,
                        input logic [63:0] rdata, output bit accepted, output bit other_ready,
                        output logic [63:0] q_addr, output bit q_we, output logic [63:0] q_wdata,
                        output bit stable, output int lat, output logic [63:0] r_data,
                        output bit r_err, output int stray);
    stable = 1'b1;
    stray  = 0;
    lat    = -1;
    r_data = '0;
    r_err  = 1'b0;
    if (is_ptw) begin
      ptw_req_valid = 1'b1;
      ptw_req_addr  = addr;
    end else begin
      dmem_req_valid = 1'b1;
      dmem_req_addr  = addr;
      dmem_req_we    = we;
      dmem_req_wdata = wdata;
    end
    #1;
    accepted    = is_ptw ? ptw_req_ready : dmem_req_ready;
    other_ready = is_ptw ? dmem_req_ready : ptw_req_ready;
    step();
    if (is_ptw) ptw_req_valid = 1'b0;
    else dmem_req_valid = 1'b0;
    q_addr  = mem_req_addr;
    q_we    = mem_req_we;
    q_wdata = mem_req_wdata;
    if (mem_req_valid !== 1'b1) stable = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (ptw_req_ready || dmem_req_ready) stray++;
      step();
      if (mem_req_valid !== 1'b1 || mem_req_addr !== q_addr || mem_req_we !== q_we ||
          mem_req_wdata !== q_wdata) stable = 1'b0;
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    if (mem_req_valid !== 1'b0) stable = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      mem_resp_valid = (k == resp_delay);
      mem_resp_data  = (k == resp_delay) ? rdata : {$urandom, $urandom};
      if (ptw_req_ready || dmem_req_ready) stray++;
      step();
      mem_resp_valid = 1'b0;
      if (is_ptw ? ptw_resp_valid : dmem_resp_valid) begin
        lat    = k + 1;
        r_data = is_ptw ? ptw_resp_data : dmem_resp_data;
        r_err  = dmem_resp_err;
        if (is_ptw ? dmem_resp_valid : ptw_resp_valid) stray++;
        break;
      end
      if (ptw_resp_valid || dmem_resp_valid) stray++;
    end
    step();
    if (ptw_resp_valid || dmem_resp_valid) stray++;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    ptw_req_valid  = 1'b0;
    ptw_req_addr   = '0;
    dmem_req_valid = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_we    = 1'b0;
    dmem_req_wdata = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({mem_req_valid, ptw_resp_valid, dmem_resp_valid, dmem_resp_err} !== 4'b0)
      $display("FAIL reset_ctrl: got %b want 0000",
               {mem_req_valid, ptw_resp_valid, dmem_resp_valid, dmem_resp_err});
    else n_pass++;
    n_checks++;
    if (ptw_resp_data !== 64'h0 || dmem_resp_data !== 64'h0)
      $display("FAIL reset_data: got ptw %h dmem %h want 0", ptw_resp_data, dmem_resp_data);
    else n_pass++;
    n_checks++;
    if (ptw_req_ready !== 1'b0 || dmem_req_ready !== 1'b0)
      $display("FAIL reset_ready: got %b%b want 00", ptw_req_ready, dmem_req_ready);
    else n_pass++;
  endtask

  task automatic test_ptw_read();
    bit acc, oth, qwe, stb, err;
    logic [63:0] qa, qd, rd;
    int lat, stray;
    do_txn(1'b1, 64'h1007, 1'b0, 64'h0, 0, 0, 64'h4001, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (acc !== 1'b1) $display("FAIL ptw_read_accept: got %b want 1", acc); else n_pass++;
    n_checks++;
    if (qa !== 64'h1000 || qwe !== 1'b0)
      $display("FAIL ptw_read_bus: got addr %h we %b want 1000/0", qa, qwe);
    else n_pass++;
    n_checks++;
    if (lat !== 1) $display("FAIL ptw_read_latency: got %0d want 1", lat); else n_pass++;
    n_checks++;
    if (rd !== 64'h4001) $display("FAIL ptw_read_data: got %h want 4001", rd); else n_pass++;
    n_checks++;
    if (stray !== 0 || stb !== 1'b1)
      $display("FAIL ptw_read_clean: got stray %0d stable %b want 0/1", stray, stb);
    else n_pass++;
    n_checks++;
    if (ptw_resp_data !== 64'h4001)
      $display("FAIL ptw_read_hold: got %h want 4001", ptw_resp_data);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit acc, oth, qwe, stb, err;
    logic [63:0] qa, qd, rd;
    int lat, stray;
    dmem_req_valid = 1'b1;
    dmem_req_addr  = 64'h8000;
    dmem_req_we    = 1'b0;
    dmem_req_wdata = 64'h0;
    do_txn(1'b1, 64'h1000, 1'b0, 64'h0, 1, 1, 64'h1111, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (acc !== 1'b1 || oth !== 1'b0)
      $display("FAIL simul_priority: got ptw %b dmem %b want 1/0", acc, oth);
    else n_pass++;
    n_checks++;
    if (qa !== 64'h1000 || rd !== 64'h1111 || stray !== 0)
      $display("FAIL simul_ptw_first: got addr %h data %h stray %0d want 1000/1111/0",
               qa, rd, stray);
    else n_pass++;
    do_txn(1'b0, 64'h8000, 1'b0, 64'h0, 0, 0, 64'h2222, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (acc !== 1'b1 || qa !== 64'h8000 || qwe !== 1'b0)
      $display("FAIL simul_dmem_second: got acc %b addr %h we %b want 1/8000/0", acc, qa, qwe);
    else n_pass++;
    n_checks++;
    if (rd !== 64'h2222 || err !== 1'b0 || stray !== 0)
      $display("FAIL simul_dmem_resp: got data %h err %b stray %0d want 2222/0/0",
               rd, err, stray);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit acc, oth, qwe, stb, err;
    logic [63:0] qa, qd, rd;
    int lat, stray;
    do_txn(1'b0, 64'h2000, 1'b1, 64'hDEAD, 5, 2, 64'h0, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (acc !== 1'b1 || qa !== 64'h2000 || qwe !== 1'b1 || qd !== 64'hDEAD)
      $display("FAIL bp_bus: got acc %b addr %h we %b wdata %h want 1/2000/1/dead",
               acc, qa, qwe, qd);
    else n_pass++;
    n_checks++;
    if (stb !== 1'b1) $display("FAIL bp_stable: got %b want 1", stb); else n_pass++;
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || stray !== 0)
      $display("FAIL bp_resp: got lat %0d err %b stray %0d want 3/0/0", lat, err, stray);
    else n_pass++;
  endtask

  task automatic test_timeouts();
    bit acc, oth, qwe, stb, err;
    logic [63:0] qa, qd, rd;
    int lat, stray;
    // PTW read, bus silent
    do_txn(1'b1, 64'h3000, 1'b0, 64'h0, 0, 1000, 64'h0, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (lat !== TO || rd !== 64'h0 || stray !== 0)
      $display("FAIL ptw_timeout: got lat %0d data %h stray %0d want %0d/0/0",
               lat, rd, stray, TO);
    else n_pass++;
    // Core load, bus silent
    do_txn(1'b0, 64'h3008, 1'b0, 64'h0, 1, 1000, 64'h0, acc, oth, qa, qwe, qd, stb, lat, rd,
           err, stray);
    n_checks++;
    if (lat !== TO || rd !== 64'h0 || err !== 1'b1 || stray !== 0)
      $display("FAIL dmem_timeout: got lat %0d data %h err %b stray %0d want %0d/0/1/0",
               lat, rd, err, stray, TO);
    else n_pass++;
    // Response in the last permitted cycle beats the timeout
    do_txn(1'b0, 64'h3010, 1'b0, 64'h0, 0, TO - 1, 64'h5A5A, acc, oth, qa, qwe, qd, stb, lat,
           rd, err, stray);
    n_checks++;
    if (lat !== TO || rd !== 64'h5A5A || err !== 1'b0)
      $display("FAIL timeout_edge: got lat %0d data %h err %b want %0d/5a5a/0",
               lat, rd, err, TO);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    ptw_req_valid = 1'b1;
    ptw_req_addr  = 64'h3000;
    step();
    ptw_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({mem_req_valid, ptw_resp_valid, dmem_resp_valid} !== 3'b0 || ptw_resp_data !== 64'h0)
      $display("FAIL rst_wait_clear: got ctl %b data %h want 000/0",
               {mem_req_valid, ptw_resp_valid, dmem_resp_valid}, ptw_resp_data);
    else n_pass++;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hBAD;
    ptw_req_valid  = 1'b1;
    ptw_req_addr   = 64'h5008;
    #1;
    n_checks++;
    if (ptw_req_ready !== 1'b1) $display("FAIL rst_wait_accept: got %b want 1", ptw_req_ready);
    else n_pass++;
    step();
    mem_resp_valid = 1'b0;
    ptw_req_valid  = 1'b0;
    n_checks++;
    if (ptw_resp_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h5008)
      $display("FAIL rst_wait_late: got resp %b req %b addr %h want 0/1/5008",
               ptw_resp_valid, mem_req_valid, mem_req_addr);
    else n_pass++;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h7777;
    step();
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ptw_resp_valid !== 1'b1 || ptw_resp_data !== 64'h7777)
      $display("FAIL rst_wait_next: got valid %b data %h want 1/7777",
               ptw_resp_valid, ptw_resp_data);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    bit acc, oth, qwe, stb, err;
    logic [63:0] qa, qd, rd;
    int lat, stray;
    bit is_ptw, we, exp_to;
    logic [63:0] addr, wdata, rdata, exp_addr, exp_data;
    logic [63:0] last_ptw, last_dmem;
    int stall, delay, exp_lat;
    reset = 1'b1;
    step();
    reset     = 1'b0;
    last_ptw  = '0;
    last_dmem = '0;
    for (int t = 0; t < 40; t++) begin
      is_ptw   = 1'($urandom_range(0, 1));
      addr     = {$urandom, $urandom};
      we       = is_ptw ? 1'b0 : 1'($urandom_range(0, 1));
      wdata    = {$urandom, $urandom};
      rdata    = {$urandom, $urandom};
      stall    = int'($urandom_range(0, 3));
      delay    = int'($urandom_range(0, TO + 1));
      exp_to   = (delay > TO - 1);
      exp_lat  = exp_to ? TO : delay + 1;
      exp_data = exp_to ? 64'h0 : rdata;
      exp_addr = is_ptw ? (addr & ~64'h7) : addr;
      n_checks++;
      if (ptw_resp_data !== last_ptw || dmem_resp_data !== last_dmem)
        $display("FAIL rnd_hold t%0d: got %h/%h want %h/%h", t, ptw_resp_data,
                 dmem_resp_data, last_ptw, last_dmem);
      else n_pass++;
      do_txn(is_ptw, addr, we, wdata, stall, delay, rdata, acc, oth, qa, qwe, qd, stb, lat, rd,
             err, stray);
      n_checks++;
      if (acc !== 1'b1 || qa !== exp_addr || qwe !== we || (!is_ptw && qd !== wdata))
        $display("FAIL rnd_req t%0d: got acc %b addr %h we %b wd %h want 1/%h/%b/%h", t, acc,
                 qa, qwe, qd, exp_addr, we, wdata);
      else n_pass++;
      n_checks++;
      if (stb !== 1'b1 || stray !== 0)
        $display("FAIL rnd_proto t%0d: got stable %b stray %0d want 1/0", t, stb, stray);
      else n_pass++;
      n_checks++;
      if (lat !== exp_lat || rd !== exp_data || err !== (!is_ptw && exp_to))
        $display("FAIL rnd_resp t%0d: got lat %0d data %h err %b want %0d/%h/%b", t, lat, rd,
                 err, exp_lat, exp_data, !is_ptw && exp_to);
      else n_pass++;
      if (is_ptw) last_ptw = exp_data;
      else last_dmem = exp_data;
    end
  endtask

  initial begin
    test_reset();
    test_ptw_read();
    test_simultaneous();
    test_backpressure();
    test_timeouts();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ptw_mem_adapter.md
# ptw_mem_adapter

Memory-port adapter between the MMU's page-table-walk (PTW) interface and the core's single data-memory port. It arbitrates PTW PTE reads against ordinary load/store traffic, with one outstanding transaction at a time. It returns PTE data on the MMU's `ptw_resp_*` interface and converts a stalled bus into an all-zero (invalid) PTE so the MMU raises a page fault instead of hanging.

## Interface
- `XLEN`, 64 — data/address width; PTE size is XLEN/8 bytes.
- `TIMEOUT`, 64 — maximum cycles spent in WAIT before the transaction is aborted; legal range 2..255.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `ptw_req_valid`  in  1  — MMU PTE read request.
- `ptw_req_addr`  in  XLEN  — PTE physical address.
- `ptw_req_ready`  out  1  — request accepted this cycle.
- `ptw_resp_valid`  out  1  — one-cycle pulse; `ptw_resp_data` is valid.
- `ptw_resp_data`  out  XLEN  — PTE value.
- `dmem_req_valid`  in  1  — core data request.
- `dmem_req_addr`  in  XLEN  — data address.
- `dmem_req_we`  in  1  — 1 = store.
- `dmem_req_wdata`  in  XLEN  — store data.
- `dmem_req_ready`  out  1  — data request accepted this cycle.
- `dmem_resp_valid`  out  1  — one-cycle completion pulse (loads and stores).
- `dmem_resp_data`  out  XLEN  — load data.
- `dmem_resp_err`  out  1  — completion was a timeout.
- `mem_req_valid`  out  1  — bus request.
- `mem_req_addr`  out  XLEN  — bus address.
- `mem_req_we`  out  1  — bus write enable.
- `mem_req_wdata`  out  XLEN  — bus write data.
- `mem_req_ready`  in  1  — bus accepted request.
- `mem_resp_valid`  in  1  — bus read data / write ack.
- `mem_resp_data`  in  XLEN  — bus read data.

## Operation
- States: IDLE, REQ, WAIT, RESP. A 1-bit `owner` register records the transaction source (PTW or DMEM).
- **IDLE:**
  - `ptw_req_ready = ptw_req_valid`.
  - `dmem_req_ready = dmem_req_valid & ~ptw_req_valid`. PTW has fixed priority.
  - On acceptance: latch address, `we`, `wdata` and `owner`, then go to REQ.
  - PTW address is forced to PTE alignment: the low log2(XLEN/8) bits are cleared. PTW requests always have `we = 0`.
- **REQ:**
  - `mem_req_*` driven from the latched registers.
  - Stay while `mem_req_ready = 0`.
  - On `mem_req_ready = 1`: go to WAIT and clear the timeout counter.
- **WAIT:**
  - Counter increments each cycle.
  - On `mem_resp_valid = 1`: capture `mem_resp_data`, go to RESP.
  - On counter reaching `TIMEOUT - 1` with no response: capture zero data, set error flag, go to RESP.
- **RESP:** one cycle.
  - Owner PTW: `ptw_resp_valid = 1`.
  - Owner DMEM: `dmem_resp_valid = 1` and `dmem_resp_err = error flag`.
  - Then go to IDLE.
- Responses arriving while not in WAIT are ignored.
- A timed-out PTW returns PTE 0 (V = 0), so the MMU faults.

## Timing
- Reset values (all registered outputs = 0):
  - state = IDLE;
  - `mem_req_valid`, `ptw_resp_valid`, `dmem_resp_valid`, `dmem_resp_err` = 0;
  - `ptw_resp_data`, `dmem_resp_data` = 0;
  - counter, `owner` and error flag = 0.
- Ready signals are combinational from state and `*_req_valid`. Ready is 0 in every state other than IDLE.
- `mem_req_valid` is asserted in REQ only and stays held, with stable address and data, until `mem_req_ready` is seen.
- Zero-wait memory (`mem_req_ready = 1` in REQ; `mem_resp_valid = 1` in the first WAIT cycle): accept at cycle N, `ptw_resp_valid` at cycle N+3. The next accept is possible at N+4.
- Response data stays stable until the next RESP.
- Both requesters valid in IDLE: PTW is accepted and the data request waits. It is accepted in the next IDLE cycle unless a new PTW request is also present.
- `mem_resp_valid` in the same cycle the counter reaches `TIMEOUT - 1`: the real response wins and the error flag stays 0.
- Reset asserted in any state: next cycle is IDLE with all outputs 0. An in-flight transaction is dropped with no response.

## Test plan
- **PTW read:** `ptw_req_addr = 0x1007`, memory returns `0x4001` one cycle after `mem_req_ready` → `mem_req_addr = 0x1000`, `mem_req_we = 0`, a single `ptw_resp_valid` pulse carrying `0x4001`, and no `dmem_resp_valid`.
- **Simultaneous requests:** PTW `0x1000` and DMEM load `0x8000` valid in the same cycle → PTW accepted first, then `mem_req_addr = 0x8000`. Responses appear in order: PTW first, then DMEM.
- **Back-pressure:** `mem_req_ready` held low for 5 cycles during a DMEM store (addr `0x2000`, data `0xDEAD`) → `mem_req_valid`, `mem_req_addr` and `mem_req_wdata` stable all 5 cycles, then one `dmem_resp_valid` with `dmem_resp_err = 0`.
- **Timeout:** `TIMEOUT = 8`, bus never responds to a PTW read → `ptw_resp_valid` with data 0 exactly 8 cycles after entering WAIT.
- **DMEM timeout:** same as above for a load → `dmem_resp_err = 1` and `dmem_resp_data = 0`.
- **Reset mid-WAIT:** `reset` asserted for 1 cycle during WAIT, then a late `mem_resp_valid` → no response pulse, and the adapter accepts a new PTW request in the cycle after reset.
